trdb_ctrl: RTL and testbench

//  Trace session controller. Sequences the encoder from config enable to active

---
 rtl/trdb_ctrl.sv | 103 ++++++++++
 tb/tb_trdb_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_ctrl.sv
// Trace session controller: arms on enable, runs a start/stop packet handshake
// with the emitter, drains the output FIFO under a timeout, then re-arms.
module trdb_ctrl #(
  parameter int DRAIN_W   = 8,
  parameter int MAX_DRAIN = 200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trace_enable_i,
  input  logic       trigger_start_i,
  input  logic       trigger_stop_i,
  output logic       start_pkt_req_o,
  input  logic       start_pkt_ack_i,
  output logic       stop_pkt_req_o,
  input  logic       stop_pkt_ack_i,
  input  logic       fifo_empty_i,
  output logic       trace_activated_o,
  output logic       encode_en_o,
  output logic       resync_rst_o,
  output logic       drain_timeout_o,
  output logic [2:0] state_o
);

  // Handshake: a req stays high from state entry until its ack is sampled high
  // on a clock edge; acks seen while the matching req is low are ignored.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    STOP  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAX_DRAIN - 1);

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               resync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      resync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      resync_q  <= (state_d == RUN) && (state_q != RUN);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (trace_enable_i) state_d = ARMED;
      ARMED: begin
        if (!trace_enable_i) begin
          state_d = IDLE;
        end else if (trigger_start_i && !trigger_stop_i) begin
          state_d   = START;
          timeout_d = 1'b0;
        end
      end
      // Once requested, the start packet is always completed before stopping.
      START: begin
        if (start_pkt_ack_i) begin
          state_d = (!trace_enable_i || trigger_stop_i) ? STOP : RUN;
        end
      end
      RUN: if (!trace_enable_i || trigger_stop_i) state_d = STOP;
      STOP: if (stop_pkt_ack_i) state_d = DRAIN;
      DRAIN: begin
        if (fifo_empty_i || (cnt_q == DRAIN_LAST)) begin
          state_d = trace_enable_i ? ARMED : IDLE;
          cnt_d   = '0;
          if (!fifo_empty_i) timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign start_pkt_req_o   = (state_q == START);
  assign stop_pkt_req_o    = (state_q == STOP);
  assign trace_activated_o = (state_q == START) || (state_q == RUN) ||
                             (state_q == STOP)  || (state_q == DRAIN);
  assign encode_en_o       = (state_q == START) || (state_q == RUN);
  assign resync_rst_o      = resync_q;
  assign drain_timeout_o   = timeout_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_trdb_ctrl.sv
// Bench for trdb_ctrl: directed session scenarios plus a randomized run
// against a cycle-level behavioural model of the session rules.
module tb_trdb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, t_start = 1'b0, t_stop = 1'b0;
  logic       s_ack = 1'b0, p_ack = 1'b0, empty = 1'b0;
  logic       s_req, p_req, act, enc, resync, to;
  logic [2:0] st;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trdb_ctrl #(.DRAIN_W(8), .MAX_DRAIN(200)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .trace_enable_i(en), .trigger_start_i(t_start), .trigger_stop_i(t_stop),
    .start_pkt_req_o(s_req), .start_pkt_ack_i(s_ack),
    .stop_pkt_req_o(p_req), .stop_pkt_ack_i(p_ack),
    .fifo_empty_i(empty),
    .trace_activated_o(act), .encode_en_o(enc), .resync_rst_o(resync),
    .drain_timeout_o(to), .state_o(st)
  );

  // Outputs are sampled 1 time unit after the active edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    t_start = 1'b1; tick(); t_start = 1'b0;
  endtask

  task automatic pulse_stop();
    t_stop = 1'b1; tick(); t_stop = 1'b0;
  endtask

  task automatic pulse_s_ack();
    s_ack = 1'b1; tick(); s_ack = 1'b0;
  endtask

  task automatic pulse_p_ack();
    p_ack = 1'b1; tick(); p_ack = 1'b0;
  endtask

  // Counts cycles spent in DRAIN; fifo_empty rises in DRAIN cycle empty_at.
  task automatic drain_count(input int empty_at, output int n);
    n = 0;
    while (st == 3'd5 && n < 300) begin
      n++;
      empty = (n >= empty_at);
      tick();
    end
    empty = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({s_req, p_req, act, enc, resync, to, st} !== 9'd0) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=%b", {s_req, p_req, act, enc, resync, to, st}, 9'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (st !== 3'd0) begin n_err++; $display("FAIL reset_idle_hold got=%0d exp=0", st); end
  endtask

  task automatic test_start_flow();
    en = 1'b1; tick();
    n_vec++;
    if (st !== 3'd1) begin n_err++; $display("FAIL arm got=%0d exp=1", st); end
    pulse_start();
    n_vec++;
    if ({st, s_req, enc, act, resync} !== {3'd2, 4'b1110}) begin
      n_err++; $display("FAIL start_entry got=%0d/%b exp=2/1110", st, {s_req, enc, act, resync});
    end
    tick(); tick();
    n_vec++;
    if (st !== 3'd2 || s_req !== 1'b1) begin n_err++; $display("FAIL start_hold got=%0d/%b exp=2/1", st, s_req); end
    pulse_s_ack();
    n_vec++;
    if ({st, s_req, enc, resync} !== {3'd3, 3'b011}) begin
      n_err++; $display("FAIL run_entry got=%0d/%b exp=3/011", st, {s_req, enc, resync});
    end
    tick();
    n_vec++;
    if (st !== 3'd3 || resync !== 1'b0) begin n_err++; $display("FAIL resync_single got=%0d/%b exp=3/0", st, resync); end
  endtask

  task automatic test_stop_drain();
    int n;
    pulse_stop();
    n_vec++;
    if ({st, p_req, enc, act} !== {3'd4, 3'b101}) begin
      n_err++; $display("FAIL stop_entry got=%0d/%b exp=4/101", st, {p_req, enc, act});
    end
    tick(); tick();
    pulse_p_ack();
    n_vec++;
    if (st !== 3'd5 || p_req !== 1'b0) begin n_err++; $display("FAIL drain_entry got=%0d/%b exp=5/0", st, p_req); end
    drain_count(10, n);
    n_vec++;
    if (n !== 10 || st !== 3'd1 || to !== 1'b0) begin
      n_err++; $display("FAIL drain_empty got=%0d/%0d/%b exp=10/1/0", n, st, to);
    end
  endtask

  task automatic go_drain();
    pulse_start(); pulse_s_ack(); tick(); pulse_stop(); pulse_p_ack();
  endtask

  task automatic test_drain_timeout();
    int n;
    go_drain();
    drain_count(1000, n);
    n_vec++;
    if (n !== 200 || st !== 3'd1 || to !== 1'b1) begin
      n_err++; $display("FAIL drain_timeout got=%0d/%0d/%b exp=200/1/1", n, st, to);
    end
    tick(); tick(); tick();
    n_vec++;
    if (to !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got=%b exp=1", to); end
    pulse_start();
    n_vec++;
    if (st !== 3'd2 || to !== 1'b0) begin n_err++; $display("FAIL timeout_clear got=%0d/%b exp=2/0", st, to); end
    pulse_s_ack();
  endtask

  task automatic test_empty_vs_timeout();
    int n;
    pulse_stop(); pulse_p_ack();
    drain_count(200, n);
    n_vec++;
    if (n !== 200 || st !== 3'd1 || to !== 1'b0) begin
      n_err++; $display("FAIL empty_wins got=%0d/%0d/%b exp=200/1/0", n, st, to);
    end
  endtask

  task automatic test_both_triggers();
    for (int i = 0; i < 3; i++) begin
      t_start = 1'b1; t_stop = 1'b1; tick();
      n_vec++;
      if (st !== 3'd1 || s_req !== 1'b0 || act !== 1'b0) begin
        n_err++; $display("FAIL both_triggers got=%0d/%b/%b exp=1/0/0", st, s_req, act);
      end
    end
    t_start = 1'b0; t_stop = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n;
    logic saw_resync;
    saw_resync = 1'b0;
    pulse_start();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_resync |= resync;
    end
    n_vec++;
    if (st !== 3'd2 || s_req !== 1'b1) begin n_err++; $display("FAIL start_kept got=%0d/%b exp=2/1", st, s_req); end
    pulse_s_ack();
    saw_resync |= resync;
    n_vec++;
    if (st !== 3'd4 || enc !== 1'b0 || saw_resync !== 1'b0) begin
      n_err++; $display("FAIL drop_to_stop got=%0d/%b/%b exp=4/0/0", st, enc, saw_resync);
    end
    pulse_p_ack();
    drain_count(3, n);
    n_vec++;
    if (n !== 3 || st !== 3'd0) begin n_err++; $display("FAIL drain_to_idle got=%0d/%0d exp=3/0", n, st); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; tick();
    pulse_start(); pulse_s_ack(); pulse_stop();
    n_vec++;
    if (st !== 3'd4 || p_req !== 1'b1) begin n_err++; $display("FAIL pre_reset got=%0d/%b exp=4/1", st, p_req); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_req, p_req, act, enc, resync, to, st} !== 9'd0) begin
      n_err++; $display("FAIL async_reset got=%b exp=%b", {s_req, p_req, act, enc, resync, to, st}, 9'd0);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    n_vec++;
    if (st !== 3'd1 || p_req !== 1'b0) begin n_err++; $display("FAIL post_reset got=%0d/%b exp=1/0", st, p_req); end
  endtask

  // Behavioural model: tracks the session phase and the drain elapsed time.
  int  m_ph, m_drain_t;
  logic m_to, m_resync;

  task automatic model_step();
    int nxt;
    nxt = m_ph;
    if (m_ph == 0) begin
      if (en) nxt = 1;
    end else if (m_ph == 1) begin
      if (!en) nxt = 0;
      else if (t_start && !t_stop) begin nxt = 2; m_to = 1'b0; end
    end else if (m_ph == 2) begin
      if (s_ack) nxt = (!en || t_stop) ? 4 : 3;
    end else if (m_ph == 3) begin
      if (!en || t_stop) nxt = 4;
    end else if (m_ph == 4) begin
      if (p_ack) begin nxt = 5; m_drain_t = 0; end
    end else begin
      m_drain_t++;
      if (empty || m_drain_t >= 200) begin
        nxt = en ? 1 : 0;
        if (!empty) m_to = 1'b1;
      end
    end
    m_resync = (nxt == 3 && m_ph != 3);
    m_ph = nxt;
  endtask

  task automatic test_random();
    logic [8:0] exp_v, got_v;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_ph = 0; m_drain_t = 0; m_to = 1'b0; m_resync = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) en = ~en;
      t_start = ($urandom_range(0, 99) < 15);
      t_stop  = ($urandom_range(0, 99) < 6);
      s_ack   = ($urandom_range(0, 99) < 30);
      p_ack   = ($urandom_range(0, 99) < 30);
      empty   = ($urandom_range(0, 99) < 10);
      model_step();
      tick();
      exp_v = {m_ph == 2, m_ph == 4, m_ph >= 2, m_ph == 2 || m_ph == 3, m_resync, m_to, 3'(m_ph)};
      got_v = {s_req, p_req, act, enc, resync, to, st};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got_v, exp_v);
      end
    end
    t_start = 1'b0; t_stop = 1'b0; s_ack = 1'b0; p_ack = 1'b0; empty = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_flow();
    test_stop_drain();
    test_drain_timeout();
    test_empty_vs_timeout();
    test_both_triggers();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
